// File: rtl/regfile_sb.sv
// Integer register file for the decode stage: NRP registered read ports with
// same-cycle write bypass, one write-back port, and a per-register pending scoreboard.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP = 3,
  parameter int SP_IDX = 2,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'('h1F400),
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP-1:0]      rd_en_i,
  input  logic [NRP*AW-1:0]   rd_addr_i,
  output logic [NRP*XLEN-1:0] rd_data_o,
  output logic [NRP-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic                stall_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [AW-1:0]   rd_a   [NRP];
  logic [XLEN-1:0] rd_val [NRP];
  logic            waw;

  // Per-port address decode, bypass selection and RAW busy detection.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NRP; k++) begin
      rd_a[k] = rd_addr_i[k*AW +: AW];
      if (rd_a[k] == '0)
        rd_val[k] = '0;
      else if (wr_en_i && (wr_addr_i == rd_a[k]))
        rd_val[k] = wr_data_i;
      else
        rd_val[k] = regs[rd_a[k]];
      rd_busy_o[k] = rd_en_i[k] & pend[rd_a[k]] & ~(wr_en_i && (wr_addr_i == rd_a[k]));
    end
  end

  // Issue handshake: iss_en_i is a valid qualified by ~stall_o; the producer
  // must hold the instruction while stall_o is high. A same-cycle write-back to
  // the issue target retires the old producer, so it does not count as WAW.
  always_comb begin
    waw     = iss_en_i & pend[iss_addr_i] & ~(wr_en_i && (wr_addr_i == iss_addr_i));
    stall_o = (|rd_busy_o) | waw;
  end

  // Clear, then set (a new producer wins), then flush overrides everything.
  always_comb begin
    pend_nxt = pend;
    if (wr_en_i)
      pend_nxt[wr_addr_i] = 1'b0;
    if (iss_en_i && (iss_addr_i != '0))
      pend_nxt[iss_addr_i] = 1'b1;
    if (flush_i)
      pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      regs[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_o <= '0;
      pend      <= '0;
    end else begin
      for (int k = 0; k < NRP; k++)
        if (rd_en_i[k])
          rd_data_o[k*XLEN +: XLEN] <= rd_val[k];
      pend <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset values, bypass, register 0,
// RAW/WAW scoreboard stalls, flush and mid-stream asynchronous reset.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRP  = 3;

  logic                clk;
  logic                reset;
  logic [NRP-1:0]      rd_en_i;
  logic [NRP*AW-1:0]   rd_addr_i;
  logic [NRP*XLEN-1:0] rd_data_o;
  logic [NRP-1:0]      rd_busy_o;
  logic                wr_en_i;
  logic [AW-1:0]       wr_addr_i;
  logic [XLEN-1:0]     wr_data_i;
  logic                iss_en_i;
  logic [AW-1:0]       iss_addr_i;
  logic                flush_i;
  logic                stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_busy_o (rd_busy_o),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .iss_en_i  (iss_en_i),
    .iss_addr_i(iss_addr_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic clear_inputs();
    rd_en_i    = '0;
    rd_addr_i  = '0;
    wr_en_i    = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    iss_en_i   = 1'b0;
    iss_addr_i = '0;
    flush_i    = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic en, input logic [AW-1:0] a);
    rd_en_i[k]          = en;
    rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1;
    // 1: reset state
    check("rst_rd0", rd_data_o[31:0], 32'h0);
    check("rst_rd1", rd_data_o[63:32], 32'h0);
    check("rst_rd2", rd_data_o[95:64], 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    step();
    step();
    reset = 1'b0;
    set_rd(0, 1'b1, 5'd2);
    set_rd(1, 1'b1, 5'd5);
    set_rd(2, 1'b1, 5'd0);
    step();
    check("sp_reset", rd_data_o[31:0], 32'h0001_F400);
    check("reg5_zero", rd_data_o[63:32], 32'h0);
    check("reg0_zero", rd_data_o[95:64], 32'h0);
    check("idle_stall", {31'b0, stall_o}, 32'h0);

    // 2: bypass, array commit, register 0, read-enable hold
    clear_inputs();
    set_wr(5'd5, 32'hDEAD_BEEF);
    set_rd(0, 1'b1, 5'd5);
    step();
    check("bypass_rd0", rd_data_o[31:0], 32'hDEAD_BEEF);
    clear_inputs();
    set_rd(1, 1'b1, 5'd5);
    set_rd(2, 1'b1, 5'd5);
    step();
    check("commit_rd1", rd_data_o[63:32], 32'hDEAD_BEEF);
    check("commit_rd2", rd_data_o[95:64], 32'hDEAD_BEEF);
    clear_inputs();
    set_wr(5'd0, 32'h0000_1234);
    set_rd(2, 1'b1, 5'd0);
    step();
    check("reg0_bypass", rd_data_o[95:64], 32'h0);
    clear_inputs();
    set_rd(1, 1'b1, 5'd0);
    step();
    check("reg0_after_wr", rd_data_o[63:32], 32'h0);
    clear_inputs();
    set_wr(5'd5, 32'h0000_0011);
    step();
    check("hold_rd0", rd_data_o[31:0], 32'hDEAD_BEEF);

    // 3: RAW stall until write-back, resolved by bypass
    clear_inputs();
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd7;
    step();
    clear_inputs();
    set_rd(1, 1'b1, 5'd7);
    #1;
    check("raw_busy", {29'b0, rd_busy_o}, 32'h2);
    check("raw_stall", {31'b0, stall_o}, 32'h1);
    step();
    check("raw_busy_held", {29'b0, rd_busy_o}, 32'h2);
    set_wr(5'd7, 32'h0000_0055);
    #1;
    check("wb_busy_drop", {29'b0, rd_busy_o}, 32'h0);
    check("wb_stall_drop", {31'b0, stall_o}, 32'h0);
    step();
    check("wb_rd1", rd_data_o[63:32], 32'h0000_0055);
    wr_en_i = 1'b0;
    #1;
    check("wb_pend_clr", {29'b0, rd_busy_o}, 32'h0);

    // 4: issue and write-back to the same register in one cycle: set wins
    clear_inputs();
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd9;
    set_wr(5'd9, 32'h0000_00AA);
    step();
    clear_inputs();
    set_rd(0, 1'b1, 5'd9);
    #1;
    check("setwin_busy", {29'b0, rd_busy_o}, 32'h1);
    check("setwin_stall", {31'b0, stall_o}, 32'h1);
    step();
    check("setwin_data", rd_data_o[31:0], 32'h0000_00AA);

    // 5: WAW stall, flush overriding a same-cycle set
    clear_inputs();
    set_wr(5'd3, 32'h0000_0033);
    step();
    clear_inputs();
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd3;
    step();
    #1;
    check("waw_stall", {31'b0, stall_o}, 32'h1);
    set_wr(5'd3, 32'h0000_0033);
    #1;
    check("waw_wb_clears", {31'b0, stall_o}, 32'h0);
    wr_en_i = 1'b0;
    flush_i = 1'b1;
    step();
    clear_inputs();
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd3;
    #1;
    check("flush_waw", {31'b0, stall_o}, 32'h0);
    clear_inputs();
    set_rd(0, 1'b1, 5'd9);
    set_rd(1, 1'b1, 5'd3);
    #1;
    check("flush_busy", {29'b0, rd_busy_o}, 32'h0);
    step();
    check("flush_reg3", rd_data_o[63:32], 32'h0000_0033);

    // 6: asynchronous reset mid-stream
    clear_inputs();
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd4;
    set_wr(5'd4, 32'h0000_0077);
    step();
    clear_inputs();
    set_rd(2, 1'b1, 5'd4);
    step();
    check("pre_rst_rd2", rd_data_o[95:64], 32'h0000_0077);
    check("pre_rst_busy", {29'b0, rd_busy_o}, 32'h4);
    reset = 1'b1;
    #1;
    check("mid_rst_rd0", rd_data_o[31:0], 32'h0);
    check("mid_rst_rd2", rd_data_o[95:64], 32'h0);
    check("mid_rst_busy", {29'b0, rd_busy_o}, 32'h0);
    check("mid_rst_stall", {31'b0, stall_o}, 32'h0);
    set_wr(5'd6, 32'h0000_0066);
    step();
    reset = 1'b0;
    clear_inputs();
    set_rd(0, 1'b1, 5'd2);
    set_rd(1, 1'b1, 5'd6);
    set_rd(2, 1'b1, 5'd4);
    #1;
    check("post_rst_busy", {29'b0, rd_busy_o}, 32'h0);
    step();
    check("post_rst_sp", rd_data_o[31:0], 32'h0001_F400);
    check("post_rst_lost_wr", rd_data_o[63:32], 32'h0);
    check("post_rst_reg4", rd_data_o[95:64], 32'h0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
